// File: rtl/instrucciones_tr_pkg.sv
// Shared definitions for the R-type execute/write-back block.
// Instruction field layout, opcode/funct constants and datapath widths.
// Imported by the ALU and the top level.
package instrucciones_tr_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int OP_W   = 6;
  localparam int SH_W   = 5;
  localparam int FN_W   = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;

  localparam logic [FN_W-1:0] F_ADD = 6'b100000;
  localparam logic [FN_W-1:0] F_SUB = 6'b100010;
  localparam logic [FN_W-1:0] F_AND = 6'b100100;
  localparam logic [FN_W-1:0] F_OR  = 6'b100101;
  localparam logic [FN_W-1:0] F_XOR = 6'b100110;
  localparam logic [FN_W-1:0] F_NOR = 6'b100111;
  localparam logic [FN_W-1:0] F_SLT = 6'b101010;

  // Field view of the 32-bit instruction word, MSB first.
  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [AW-1:0]   rs;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   rd;
    logic [SH_W-1:0] shamt;
    logic [FN_W-1:0] funct;
  } instr_t;

endpackage

// File: rtl/instrucciones_tr_alu32.sv
// Purpose: combinational 32-bit ALU for the supported R-type funct codes.
// Latency: zero cycles, purely combinational.
// Backpressure: none; valid_o flags whether funct is a supported operation.
module instrucciones_tr_alu32
  import instrucciones_tr_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [FN_W-1:0]   funct_i,
  output logic [DATA_W-1:0] result_o,
  output logic              valid_o
);

  // Operation select; unsupported funct codes yield zero and valid_o low.
  always_comb begin
    result_o = '0;
    valid_o  = 1'b1;
    case (funct_i)
      F_ADD:   result_o = a_i + b_i;
      F_SUB:   result_o = a_i - b_i;
      F_AND:   result_o = a_i & b_i;
      F_OR:    result_o = a_i | b_i;
      F_XOR:   result_o = a_i ^ b_i;
      F_NOR:   result_o = ~(a_i | b_i);
      F_SLT:   result_o = ($signed(a_i) < $signed(b_i)) ? DATA_W'(1) : '0;
      default: begin
        result_o = '0;
        valid_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instrucciones_tr.sv
// Purpose: R-type execute and write-back stage with an internal 32x32 register file.
// Latency: RES is combinational; register write and TR_ZF update on the next rising edge.
// Backpressure: none; the driver holds TR one clock per instruction, held TR re-executes.
module instrucciones_tr
  import instrucciones_tr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       TR,
  output logic              TR_ZF,
  output logic [DATA_W-1:0] RES
);

  instr_t              instr;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_vld;
  logic                instr_vld;
  logic                zf_q;
  logic                zf_d;
  logic                unused_shamt;

  assign instr        = instr_t'(TR);
  // Shift amount has no meaning for the supported operations.
  assign unused_shamt = ^instr.shamt;

  // Asynchronous read ports; register 0 is hardwired to zero.
  assign opa = (instr.rs == '0) ? '0 : regs_q[instr.rs];
  assign opb = (instr.rt == '0) ? '0 : regs_q[instr.rt];

  instrucciones_tr_alu32 u_alu (
    .a_i      (opa),
    .b_i      (opb),
    .funct_i  (instr.funct),
    .result_o (alu_res),
    .valid_o  (alu_vld)
  );

  assign instr_vld = (instr.opcode == OP_RTYPE) && alu_vld;
  assign RES       = instr_vld ? alu_res : '0;
  assign zf_d      = (RES == '0);
  assign TR_ZF     = zf_q;

  // Register file write-back and zero flag; reset loads each register with its index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      zf_q <= 1'b0;
    end else if (instr_vld) begin
      if (instr.rd != '0) begin
        regs_q[instr.rd] <= RES;
      end
      zf_q <= zf_d;
    end
  end

endmodule

// File: tb/tb_instrucciones_tr.sv
// Directed bench for the R-type execute block.
// Drives instructions on the falling edge, samples RES mid-cycle and TR_ZF after the rising edge.
// Registers are observed by issuing OR rX,r0 into r0 and reading RES.
module tb_instrucciones_tr;

  logic        clk;
  logic        rst;
  logic [31:0] TR;
  logic        TR_ZF;
  logic [31:0] RES;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  instrucciones_tr dut (
    .clk   (clk),
    .rst   (rst),
    .TR    (TR),
    .TR_ZF (TR_ZF),
    .RES   (RES)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  // Issue one instruction for exactly one rising edge.
  task automatic exec(input logic [31:0] tr, output logic [31:0] res, output logic zf);
    @(negedge clk);
    TR = tr;
    #1 res = RES;
    @(posedge clk);
    #1 zf = TR_ZF;
    TR = NOP;
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    logic zf;
    exec(rtype(idx, 5'd0, 5'd0, 6'b100101), val, zf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    TR  = NOP;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    total_cnt++;
    if (TR_ZF !== 1'b0) $display("FAIL reset_zf got %b want 0", TR_ZF); else pass_cnt++;
    read_reg(5'd12, v);
    total_cnt++;
    if (v !== 32'd12) $display("FAIL reset_r12 got %h want %h", v, 32'd12); else pass_cnt++;
    read_reg(5'd31, v);
    total_cnt++;
    if (v !== 32'd31) $display("FAIL reset_r31 got %h want %h", v, 32'd31); else pass_cnt++;
  endtask

  task automatic test_add();
    logic [31:0] r, v;
    logic        z;
    do_reset();
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b100000), r, z);
    total_cnt++;
    if (r !== 32'd21) $display("FAIL add_res got %h want %h", r, 32'd21); else pass_cnt++;
    total_cnt++;
    if (z !== 1'b0) $display("FAIL add_zf got %b want 0", z); else pass_cnt++;
    read_reg(5'd12, v);
    total_cnt++;
    if (v !== 32'd21) $display("FAIL add_r12 got %h want %h", v, 32'd21); else pass_cnt++;
  endtask

  task automatic test_logic();
    logic [31:0] r, v;
    logic        z;
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b100010), r, z);
    total_cnt++;
    if (r !== 32'hFFFF_FFFF || z !== 1'b0)
      $display("FAIL sub_res got %h/%b want ffffffff/0", r, z);
    else pass_cnt++;
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b100100), r, z);
    total_cnt++;
    if (r !== 32'd10) $display("FAIL and_res got %h want %h", r, 32'd10); else pass_cnt++;
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b100101), r, z);
    total_cnt++;
    if (r !== 32'd11) $display("FAIL or_res got %h want %h", r, 32'd11); else pass_cnt++;
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b100110), r, z);
    total_cnt++;
    if (r !== 32'd1) $display("FAIL xor_res got %h want %h", r, 32'd1); else pass_cnt++;
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b100111), r, z);
    total_cnt++;
    if (r !== 32'hFFFF_FFF4) $display("FAIL nor_res got %h want fffffff4", r); else pass_cnt++;
    read_reg(5'd12, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFF4) $display("FAIL nor_r12 got %h want fffffff4", v); else pass_cnt++;
  endtask

  task automatic test_nop();
    logic [31:0] r, v;
    logic        z;
    // AND r3,r4 -> r5 yields zero, so TR_ZF is 1 going into the NOPs.
    exec(rtype(5'd3, 5'd4, 5'd5, 6'b100100), r, z);
    total_cnt++;
    if (z !== 1'b1) $display("FAIL nop_pre_zf got %b want 1", z); else pass_cnt++;
    exec(rtype(5'd10, 5'd11, 5'd12, 6'b000011), r, z);
    total_cnt++;
    if (r !== 32'd0 || z !== 1'b1)
      $display("FAIL badfunct got %h/%b want 00000000/1", r, z);
    else pass_cnt++;
    exec({6'd8, 5'd10, 5'd11, 5'd12, 5'd0, 6'b100000}, r, z);
    total_cnt++;
    if (r !== 32'd0 || z !== 1'b1)
      $display("FAIL badopcode got %h/%b want 00000000/1", r, z);
    else pass_cnt++;
    read_reg(5'd12, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFF4) $display("FAIL nop_r12 got %h want fffffff4", v); else pass_cnt++;
  endtask

  task automatic test_r345();
    logic [31:0] r, v;
    logic        z;
    do_reset();
    exec(rtype(5'd3, 5'd4, 5'd5, 6'b101010), r, z);
    read_reg(5'd5, v);
    total_cnt++;
    if (v !== 32'd1) $display("FAIL slt_r5 got %h want %h", v, 32'd1); else pass_cnt++;
    exec(rtype(5'd3, 5'd4, 5'd5, 6'b100010), r, z);
    read_reg(5'd5, v);
    total_cnt++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL sub_r5 got %h want ffffffff", v); else pass_cnt++;
    exec(rtype(5'd3, 5'd4, 5'd5, 6'b100101), r, z);
    read_reg(5'd5, v);
    total_cnt++;
    if (v !== 32'd7) $display("FAIL or_r5 got %h want %h", v, 32'd7); else pass_cnt++;
    exec(rtype(5'd3, 5'd4, 5'd5, 6'b100100), r, z);
    total_cnt++;
    if (r !== 32'd0 || z !== 1'b1)
      $display("FAIL and_r5 got %h/%b want 00000000/1", r, z);
    else pass_cnt++;
  endtask

  task automatic test_slt_signed();
    logic [31:0] r;
    logic        z;
    exec(rtype(5'd3, 5'd4, 5'd6, 6'b100010), r, z);
    exec(rtype(5'd6, 5'd1, 5'd7, 6'b101010), r, z);
    total_cnt++;
    if (r !== 32'd1) $display("FAIL slt_neg_lt got %h want %h", r, 32'd1); else pass_cnt++;
    exec(rtype(5'd1, 5'd6, 5'd7, 6'b101010), r, z);
    total_cnt++;
    if (r !== 32'd0 || z !== 1'b1)
      $display("FAIL slt_neg_ge got %h/%b want 00000000/1", r, z);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, v;
    do_reset();
    // ADD r1,r2 -> r1 held for two edges: 1+2=3, then 3+2=5.
    @(negedge clk);
    TR = rtype(5'd1, 5'd2, 5'd1, 6'b100000);
    #1 r = RES;
    total_cnt++;
    if (r !== 32'd3) $display("FAIL alias_first got %h want %h", r, 32'd3); else pass_cnt++;
    @(posedge clk);
    #1 r = RES;
    total_cnt++;
    if (r !== 32'd5) $display("FAIL alias_second got %h want %h", r, 32'd5); else pass_cnt++;
    @(posedge clk);
    #1 TR = NOP;
    read_reg(5'd1, v);
    total_cnt++;
    if (v !== 32'd5) $display("FAIL alias_r1 got %h want %h", v, 32'd5); else pass_cnt++;
  endtask

  task automatic test_r0();
    logic [31:0] r, v;
    logic        z;
    exec(rtype(5'd3, 5'd2, 5'd0, 6'b100000), r, z);
    total_cnt++;
    if (r !== 32'd5 || z !== 1'b0)
      $display("FAIL r0_add got %h/%b want 00000005/0", r, z);
    else pass_cnt++;
    read_reg(5'd0, v);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL r0_read got %h want 0", v); else pass_cnt++;
    exec(rtype(5'd2, 5'd2, 5'd0, 6'b100010), r, z);
    total_cnt++;
    if (z !== 1'b1) $display("FAIL r0_zf got %b want 1", z); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, v;
    logic        z;
    exec(rtype(5'd1, 5'd1, 5'd12, 6'b100010), r, z);
    total_cnt++;
    if (z !== 1'b1) $display("FAIL mid_pre_zf got %b want 1", z); else pass_cnt++;
    // Same zeroing write with reset asserted: reset must win.
    @(negedge clk);
    TR  = rtype(5'd1, 5'd1, 5'd12, 6'b100010);
    rst = 1'b1;
    @(posedge clk);
    #1 z = TR_ZF;
    rst = 1'b0;
    TR  = NOP;
    total_cnt++;
    if (z !== 1'b0) $display("FAIL mid_zf got %b want 0", z); else pass_cnt++;
    read_reg(5'd12, v);
    total_cnt++;
    if (v !== 32'd12) $display("FAIL mid_r12 got %h want %h", v, 32'd12); else pass_cnt++;
    read_reg(5'd1, v);
    total_cnt++;
    if (v !== 32'd1) $display("FAIL mid_r1 got %h want %h", v, 32'd1); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    TR  = NOP;
    test_reset();
    test_add();
    test_logic();
    test_nop();
    test_r345();
    test_slt_signed();
    test_back_to_back();
    test_r0();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instrucciones_tr.md
Name: instrucciones_tr

Overview:
- Single-cycle MIPS-style R-type execution block: decodes a 32-bit instruction word TR, reads two operands from an internal 32x32 register file, performs the ALU operation selected by the funct field, writes the result back to rd, and exposes a registered zero flag TR_ZF.
- Sits in the CPU datapath after instruction fetch. It is the execute and write-back stage for R-type instructions.

Parameters:
- DATA_W, 32, datapath and register width
- NREGS, 32, register file depth; address width is 5 bits

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- TR  input  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- TR_ZF  output  1  registered zero flag of the last executed valid instruction
- RES  output  32  combinational ALU result for the current TR; 0 when TR is not a valid R-type instruction

Behaviour:
- Reset (rst=1 at a rising edge): regs[i] <= i for i=0..31; TR_ZF <= 0. Reset overrides any write in the same cycle.
- Valid instruction: opcode==6'd0 and funct is in the supported set below. Anything else is a NOP: no register write, TR_ZF holds, RES=0.
- Supported funct codes:
  - 100000 ADD: A+B, wraps modulo 2^32, no overflow trap
  - 100010 SUB: A-B, two's complement wrap
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 101010 SLT: signed A<B gives 32'd1, otherwise 0
- Operands: A=regs[rs], B=regs[rt]. Reads are combinational and asynchronous.
- shamt is ignored.
- Register 0 reads as 0 always. Writes to rd=0 are discarded, but TR_ZF still updates from RES.
- Latency: RES is combinational in the same cycle. On the next rising edge of a valid instruction: regs[rd] <= RES and TR_ZF <= (RES==0).
- rd equal to rs or rt: operands are the pre-edge values; the new value is visible after the edge.
- TR is held stable by the driver for at least one clock. If TR is held for several cycles, the instruction re-executes every cycle. This is idempotent unless rd aliases rs or rt.

Decomposition:
- Shared package: opcode constant OP_RTYPE=6'd0, funct constants (F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT), and field-slice widths.
- Sub-modules:
  - alu32, combinational: A, B, funct in; result and valid out.
  - Register file kept inline or as regfile32x32. Two async read ports, one sync write port, reset initialisation to index values.

Test Plan:
- Reset, then TR = {0, rs=10, rt=11, rd=12, 0, ADD}: RES=21. After the edge, regs[12]=21 and TR_ZF=0.
- SUB r10,r11 into r12: RES=32'hFFFFFFFF, TR_ZF=0. AND r10,r11: RES=10. OR (100101): RES=11. XOR (100110): RES=1.
- Invalid funct 000011 with rs=10, rt=11, rd=12: no write (regs[12] unchanged), TR_ZF unchanged, RES=0. Also nonzero opcode gives a NOP.
- rs=3, rt=4, rd=5: SLT gives r5=1. SUB gives r5=32'hFFFFFFFF. OR gives 7. AND gives 0 and TR_ZF=1.
- SLT with negative operand: first load r6=FFFFFFFF via SUB r3,r4 into r6, then SLT r6,r1: result 1 (signed compare).
- Write to rd=0 (ADD r1,r2 into r0): r0 still reads 0. Assert rst mid-sequence: all regs return to index values and TR_ZF=0 on that edge.
